// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM state encoding and line-level
// bit constants. The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  // Line levels for the framing bits; the idle line sits at the stop level.
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Transmitter FSM states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: bit_done is high on the last clk cycle of each
// CLKS_PER_BIT-long bit period. restart realigns the period to start on the
// next cycle, so every frame begins with a full-length start bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Free-running modulo-CLKS_PER_BIT counter, zeroed on reset or restart.
  always_ff @(posedge clk) begin
    if (!reset || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_done = (cnt == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a one-entry holding register.
// Optional feature macro: UART_TX_PARITY_EN adds the parity_odd port and a
// parity bit after the data bits (XOR of data, inverted when parity_odd=1).
// Handshake: a word transfers on every clk edge where in_valid && in_ready;
// in_ready is high exactly when the holding register is empty, and in_valid
// is ignored while in_ready is low. in_data need not be held after transfer.
// dbg_state mirrors the FSM state for observation.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
`ifdef UART_TX_PARITY_EN
  input  logic                 parity_odd,
`endif
  output logic                 tx,
  output logic                 busy,
  output uart_state_e          dbg_state
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  uart_state_e          state;
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_data;
  logic [DATA_BITS-1:0] shift_q;
  logic [3:0]           bit_idx;
  logic                 bit_done;
  logic                 accept;
  logic                 restart;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  assign in_ready  = ~hold_full;
  assign accept    = in_valid & ~hold_full;
  assign dbg_state = state;

  // A frame starts whenever a word is waiting and the line is free: from IDLE,
  // or straight after the final stop bit so consecutive frames have no gap.
  assign restart = hold_full &
                   ((state == IDLE) ||
                    ((state == STOP) && bit_done && (bit_idx == LAST_STOP)));

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .bit_done (bit_done)
  );

  // Holding register: fills on handshake, empties when a frame starts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_data <= in_data;
    end else if (restart) begin
      hold_full <= 1'b0;
    end
  end

  // Frame FSM with registered tx/busy; the shift register feeds data LSB first.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      tx         <= IDLE_LEVEL;
      busy       <= 1'b0;
      shift_q    <= '0;
      bit_idx    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (restart) begin
      state      <= START;
      tx         <= START_BIT;
      busy       <= 1'b1;
      shift_q    <= hold_data;
      bit_idx    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= (^hold_data) ^ parity_odd;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx   <= IDLE_LEVEL;
          busy <= 1'b0;
        end
        START: begin
          if (bit_done) begin
            state   <= DATA;
            tx      <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= parity_bit;
`else
              state <= STOP;
              tx    <= STOP_BIT;
`endif
              bit_idx <= '0;
            end else begin
              tx      <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            state   <= STOP;
            tx      <= STOP_BIT;
            bit_idx <= '0;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            if (bit_idx == LAST_STOP) begin
              state <= IDLE;
              tx    <= IDLE_LEVEL;
              busy  <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= IDLE_LEVEL;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three instances (8N1 @4 clk/bit, 8N2 @2 clk/bit,
// 5N1 @3 clk/bit) against a frame-level reference model. Honours
// UART_TX_PARITY_EN when defined.
module tb_uart_tx_param;
  import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk;
  logic       reset;
  logic [8:0] in_data [3];
  logic [2:0] in_valid;
  logic [2:0] par_odd;
  wire  [2:0] tx_w;
  wire  [2:0] busy_w;
  wire  [2:0] rdy_w;
  uart_state_e st0, st1, st2;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state per instance.
  bit          act [3];
  bit          hv  [3];
  logic [8:0]  hw  [3];
  logic [15:0] fb  [3];
  int          nb  [3];
  int          cyc [3];

  // Busy statistics per instance.
  int busy_tot [3];
  int falls    [3];
  bit busy_prev[3];

  function automatic int dbits(int k);
    case (k)
      0: return 8;
      1: return 8;
      default: return 5;
    endcase
  endfunction

  function automatic int sbits(int k);
    return (k == 1) ? 2 : 1;
  endfunction

  function automatic int clks(int k);
    case (k)
      0: return 4;
      1: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int frame_cyc(int k);
    return (1 + dbits(k) + P + sbits(k)) * clks(k);
  endfunction

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(8), .STOP_BITS(1), .CLKS_PER_BIT(4)) u_dut0 (
    .clk(clk), .reset(reset), .in_data(in_data[0][7:0]), .in_valid(in_valid[0]),
    .in_ready(rdy_w[0]),
`ifdef UART_TX_PARITY_EN
    .parity_odd(par_odd[0]),
`endif
    .tx(tx_w[0]), .busy(busy_w[0]), .dbg_state(st0));

  uart_tx_param #(.DATA_BITS(8), .STOP_BITS(2), .CLKS_PER_BIT(2)) u_dut1 (
    .clk(clk), .reset(reset), .in_data(in_data[1][7:0]), .in_valid(in_valid[1]),
    .in_ready(rdy_w[1]),
`ifdef UART_TX_PARITY_EN
    .parity_odd(par_odd[1]),
`endif
    .tx(tx_w[1]), .busy(busy_w[1]), .dbg_state(st1));

  uart_tx_param #(.DATA_BITS(5), .STOP_BITS(1), .CLKS_PER_BIT(3)) u_dut2 (
    .clk(clk), .reset(reset), .in_data(in_data[2][4:0]), .in_valid(in_valid[2]),
    .in_ready(rdy_w[2]),
`ifdef UART_TX_PARITY_EN
    .parity_odd(par_odd[2]),
`endif
    .tx(tx_w[2]), .busy(busy_w[2]), .dbg_state(st2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      if (n_errs <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model update for one clock edge: a frame is a list of bit levels, each
  // lasting clks(k) cycles; a waiting word starts as soon as the line is free.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      bit acc;
      if (!reset) begin
        act[k] = 1'b0;
        hv[k]  = 1'b0;
        cyc[k] = 0;
      end else begin
        acc = in_valid[k] && !hv[k];
        if (act[k]) begin
          cyc[k]++;
          if (cyc[k] == nb[k] * clks(k)) act[k] = 1'b0;
        end
        if (!act[k] && hv[k]) begin
          fb[k] = '1;
          fb[k][0] = 1'b0;
          for (int i = 0; i < dbits(k); i++) fb[k][1+i] = hw[k][i];
`ifdef UART_TX_PARITY_EN
          fb[k][1+dbits(k)] = ($countones(hw[k]) % 2 == 1) ^ par_odd[k];
`endif
          nb[k]  = 1 + dbits(k) + P + sbits(k);
          cyc[k] = 0;
          act[k] = 1'b1;
          hv[k]  = 1'b0;
        end
        if (acc) begin
          hv[k] = 1'b1;
          hw[k] = in_data[k] & 9'((1 << dbits(k)) - 1);
        end
      end
    end
  endtask

  // One clock: model at the rising edge, compare outputs at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      logic exp_tx;
      exp_tx = act[k] ? fb[k][cyc[k] / clks(k)] : 1'b1;
      check($sformatf("tx%0d", k), 32'(tx_w[k]), 32'(exp_tx));
      check($sformatf("busy%0d", k), 32'(busy_w[k]), 32'(act[k]));
      check($sformatf("in_ready%0d", k), 32'(rdy_w[k]), 32'(!hv[k]));
      busy_tot[k] += 32'(busy_w[k]);
      if (busy_prev[k] && !busy_w[k]) falls[k]++;
      busy_prev[k] = busy_w[k];
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input int k, input logic [8:0] w, input logic p);
    in_data[k]  = w;
    par_odd[k]  = p;
    in_valid[k] = 1'b1;
    step();
    in_valid[k] = 1'b0;
  endtask

  task automatic clr_stats();
    for (int k = 0; k < 3; k++) begin
      busy_tot[k] = 0;
      falls[k]    = 0;
    end
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = '0;
    par_odd  = '0;
    for (int k = 0; k < 3; k++) begin
      in_data[k]   = '0;
      busy_prev[k] = 1'b0;
    end
    clr_stats();

    // Reset state
    wait_n(3);
    check("rst_tx0", 32'(tx_w[0]), 32'd1);
    check("rst_busy0", 32'(busy_w[0]), 32'd0);
    check("rst_ready0", 32'(rdy_w[0]), 32'd1);
    check("rst_state0", 32'(st0), 32'(IDLE));
    check("rst_state1", 32'(st1), 32'(IDLE));
    check("rst_state2", 32'(st2), 32'(IDLE));
    reset = 1'b1;
    wait_n(2);

    // 0xA5, 8 data bits, 4 clk/bit
    clr_stats();
    pulse(0, 9'h0A5, 1'b0);
    wait_n(50);
    check("a5_busy_len", 32'(busy_tot[0]), 32'(frame_cyc(0)));

    // Same word with odd parity selected
    clr_stats();
    pulse(0, 9'h0A5, 1'b1);
    wait_n(50);
    check("a5_odd_busy_len", 32'(busy_tot[0]), 32'(frame_cyc(0)));

    // Back-to-back frames with in_valid held high, 2 stop bits
    clr_stats();
    in_data[1]  = 9'h001;
    in_valid[1] = 1'b1;
    step();
    in_data[1]  = 9'h002;
    wait_n(3);
    in_valid[1] = 1'b0;
    wait_n(60);
    check("b2b_busy_len", 32'(busy_tot[1]), 32'(2 * frame_cyc(1)));
    check("b2b_busy_falls", 32'(falls[1]), 32'd1);

    // Reset during DATA with a word pending
    pulse(0, 9'h03C, 1'b0);
    step();
    pulse(0, 9'h055, 1'b0);
    wait_n(14);
    check("mid_state", 32'(st0), 32'(DATA));
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("abort_tx", 32'(tx_w[0]), 32'd1);
    check("abort_busy", 32'(busy_w[0]), 32'd0);
    check("abort_ready", 32'(rdy_w[0]), 32'd1);
    clr_stats();
    pulse(0, 9'h096, 1'b1);
    wait_n(60);
    check("after_abort_len", 32'(busy_tot[0]), 32'(frame_cyc(0)));

    // 5 data bits of ones
    clr_stats();
    pulse(2, 9'h01F, 1'b0);
    wait_n(40);
    check("five_bit_len", 32'(busy_tot[2]), 32'(frame_cyc(2)));

    // Word offered while the holding register is full is dropped
    clr_stats();
    pulse(0, 9'h011, 1'b0);
    step();
    pulse(0, 9'h022, 1'b1);
    check("full_not_ready", 32'(rdy_w[0]), 32'd0);
    pulse(0, 9'h033, 1'b0);
    wait_n(120);
    check("drop_busy_len", 32'(busy_tot[0]), 32'(2 * frame_cyc(0)));
    check("drop_falls", 32'(falls[0]), 32'd1);

    // Random traffic with occasional resets
    for (int n = 0; n < 2500; n++) begin
      reset = ($urandom_range(0, 299) != 0);
      for (int k = 0; k < 3; k++) begin
        in_valid[k] = ($urandom_range(0, 3) == 0);
        in_data[k]  = 9'($urandom);
        par_odd[k]  = 1'($urandom_range(0, 1));
      end
      step();
    end
    reset    = 1'b1;
    in_valid = '0;
    wait_n(100);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("final_idle_busy%0d", k), 32'(busy_w[k]), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
